// File: rtl/count9_pkg.sv
// count9_pkg
// Shared types and constants for the count9 BCD display path: converter FSM
// states, conversion widths, and active-low seven-segment patterns
// ({g,f,e,d,c,b,a}, 0 = segment lit).
package count9_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ITER_COUNT = 9;   // one shift per binary input bit
  localparam int ITER_W     = 4;
  localparam int BIN_W      = 9;
  localparam int BCD_W      = 12;
  localparam int SR_W       = BCD_W + BIN_W;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Index i holds the pattern for decimal digit i.
  localparam logic [9:0][6:0] SEG_DIGIT = {
    7'b0010000,   // 9
    7'b0000000,   // 8
    7'b1111000,   // 7
    7'b0000010,   // 6
    7'b0010010,   // 5
    7'b0011001,   // 4
    7'b0110000,   // 3
    7'b0100100,   // 2
    7'b1111001,   // 1
    7'b1000000    // 0
  };

endpackage

// File: rtl/count9_bcd_display_seg7_decode.sv
// seg7_decode
// Combinational nibble to active-low seven-segment decoder.
//   nibble : BCD digit to show (10..15 decode to blank)
//   blank  : force all segments off
//   seg    : {g,f,e,d,c,b,a}, active-low
module seg7_decode
  import count9_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      for (int i = 0; i < 10; i++) begin
        if (nibble == 4'(i)) seg = SEG_DIGIT[i];
      end
    end
  end

endmodule

// File: rtl/count9_bcd_display.sv
// count9_bcd_display
// Converts the 9-bit counter value to three BCD digits with a sequential
// shift-add-3 engine and scans them onto a 3-digit common-anode display.
//   clk   : system clock, rising edge
//   clr   : asynchronous active-high reset
//   count : binary value, sampled only when a load is accepted
//   load  : start a conversion (ignored unless idle)
//   busy  : conversion in progress
//   done  : one-cycle pulse when bcd updates
//   bcd   : {hundreds, tens, ones}
//   an    : active-low digit enables, bit0 = ones
//   seg   : active-low segments {g,f,e,d,c,b,a}
module count9_bcd_display
  import count9_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [8:0]   count,
  input  logic         load,
  output logic         busy,
  output logic         done,
  output logic [11:0]  bcd,
  output logic [2:0]   an,
  output logic [6:0]   seg
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_t            state;
  logic [SR_W-1:0]   sr;
  logic [SR_W-1:0]   sr_adj;
  logic [ITER_W-1:0] iter;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
  always_comb begin
    sr_adj = sr;
    for (int k = 0; k < 3; k++) begin
      if (sr[BIN_W + 4*k +: 4] >= 4'd5)
        sr_adj[BIN_W + 4*k +: 4] = sr[BIN_W + 4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      sr    <= '0;
      iter  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            sr    <= {{BCD_W{1'b0}}, count};
            iter  <= '0;
            busy  <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          sr <= {sr_adj[SR_W-2:0], 1'b0};
          if (iter == ITER_W'(ITER_COUNT - 1)) state <= DONE;
          else                                 iter  <= iter + 1'b1;
        end
        DONE: begin
          bcd   <= sr[SR_W-1 -: BCD_W];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Free-running digit scanner.
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        digit_idx;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      scan_cnt  <= '0;
      digit_idx <= 2'd0;
    end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt  <= '0;
      digit_idx <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  assign an = ~(3'b001 << digit_idx);

  logic [3:0] nib;
  logic       blank;
  logic       hund_zero;
  logic       tens_zero;

  assign hund_zero = (bcd[11:8] == 4'd0);
  assign tens_zero = (bcd[7:4] == 4'd0);

  always_comb begin
    nib   = bcd[3:0];
    blank = 1'b0;
    case (digit_idx)
      2'd1: begin
        nib   = bcd[7:4];
        blank = BLANK_LZ && hund_zero && tens_zero;
      end
      2'd2: begin
        nib   = bcd[11:8];
        blank = BLANK_LZ && hund_zero;
      end
      default: ;
    endcase
  end

  seg7_decode u_seg7_decode (
    .nibble (nib),
    .blank  (blank),
    .seg    (seg)
  );

endmodule

// File: tb/tb_count9_bcd_display.sv
module tb_count9_bcd_display;

  logic       clk   = 1'b0;
  logic       clr   = 1'b0;
  logic       load  = 1'b0;
  logic [8:0] count = '0;

  logic        busy1, done1, busy0, done0;
  logic [11:0] bcd1, bcd0;
  logic [2:0]  an1, an0;
  logic [6:0]  seg1, seg0;

  count9_bcd_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut_blz1 (
    .clk(clk), .clr(clr), .count(count), .load(load),
    .busy(busy1), .done(done1), .bcd(bcd1), .an(an1), .seg(seg1)
  );

  count9_bcd_display #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_blz0 (
    .clk(clk), .clr(clr), .count(count), .load(load),
    .busy(busy0), .done(done0), .bcd(bcd0), .an(an0), .seg(seg0)
  );

  always #5 clk = ~clk;

  int cyc = 0;   // posedges so far
  int rel = 0;   // posedges since reset release
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (clr) rel <= 0;
    else     rel <= rel + 1;
  end

  typedef struct {
    int edge_n;
    int val;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  int   last_acc = -1000;
  int   disp     = 0;

  function automatic logic [11:0] to_bcd(int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] seg_model(int v, int idx, bit blz);
    logic [6:0] pats [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000};
    int h = v / 100;
    int t = (v / 10) % 10;
    int o = v % 10;
    if (idx == 2) return (blz && h == 0) ? 7'b1111111 : pats[h];
    if (idx == 1) return (blz && h == 0 && t == 0) ? 7'b1111111 : pats[t];
    return pats[o];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every cycle against the reference model.
  always @(negedge clk) begin
    bit         exp_done;
    bit         exp_busy;
    int         idx;
    logic [2:0] an_exp;
    if (!clr) begin
      exp_done = (sbq.size() > 0) && (sbq[0].edge_n + 10 == cyc);
      exp_busy = (cyc - last_acc >= 0) && (cyc - last_acc <= 9);
      chk("done_blz1", done1, exp_done);
      chk("done_blz0", done0, exp_done);
      if (exp_done) begin
        disp = sbq[0].val;
        sbq.pop_front();
      end
      chk("bcd_blz1", bcd1, to_bcd(disp));
      chk("bcd_blz0", bcd0, to_bcd(disp));
      chk("busy_blz1", busy1, exp_busy);
      chk("busy_blz0", busy0, exp_busy);
      idx    = (rel / 4) % 3;
      an_exp = ~(3'b001 << idx);
      chk("an_blz1", an1, an_exp);
      chk("an_blz0", an0, an_exp);
      chk("seg_blz1", seg1, seg_model(disp, idx, 1'b1));
      chk("seg_blz0", seg0, seg_model(disp, idx, 1'b0));
    end
  end

  // One clock edge of stimulus; records an accepted load in the scoreboard.
  task automatic do_edge(bit ld, logic [8:0] v);
    @(negedge clk);
    #1;
    count = v;
    load  = ld;
    @(posedge clk);
    #1;
    if (ld && (cyc - last_acc >= 11)) begin
      sbq.push_back('{cyc, int'(v)});
      last_acc = cyc;
    end
    load  = 1'b0;
    count = 9'($urandom_range(0, 511));
  endtask

  task automatic idle(int n);
    repeat (n) do_edge(1'b0, 9'($urandom_range(0, 511)));
  endtask

  task automatic do_reset(bit check);
    #2;
    clr = 1'b1;
    #1;
    if (check) begin
      chk("rst_busy", busy1, 1'b0);
      chk("rst_done", done1, 1'b0);
      chk("rst_bcd", bcd1, 12'h000);
      chk("rst_an", an1, 3'b110);
      chk("rst_seg", seg1, 7'b1000000);
      chk("rst_seg_blz0", seg0, 7'b1000000);
      chk("rst_bcd_blz0", bcd0, 12'h000);
    end
    sbq.delete();
    last_acc = -1000;
    disp     = 0;
    @(posedge clk);
    @(negedge clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    do_reset(1'b1);

    do_edge(1'b1, 9'd255);
    idle(12);
    chk("single_255", bcd1, 12'h255);

    do_edge(1'b1, 9'd0);   idle(11);
    chk("extreme_0", bcd1, 12'h000);
    do_edge(1'b1, 9'd511); idle(11);
    chk("extreme_511", bcd1, 12'h511);
    do_edge(1'b1, 9'd100); idle(11);
    chk("extreme_100", bcd1, 12'h100);

    do_edge(1'b1, 9'd37);
    idle(2);
    do_edge(1'b1, 9'd400);
    idle(10);
    chk("load_during_busy", bcd1, 12'h037);
    do_edge(1'b1, 9'd400);
    idle(11);
    chk("later_load_400", bcd1, 12'h400);

    repeat (25) do_edge(1'b1, 9'($urandom_range(0, 511)));
    idle(11);

    do_edge(1'b1, 9'd7);
    idle(40);
    chk("scan_value_7", bcd1, 12'h007);

    do_edge(1'b1, 9'd127);
    idle(11);
    chk("pre_reset_127", bcd1, 12'h127);
    do_edge(1'b1, 9'd300);
    idle(2);
    do_reset(1'b1);

    do_edge(1'b1, 9'd200);
    idle(4);
    do_reset(1'b0);
    do_edge(1'b1, 9'd42);
    idle(11);
    chk("abort_then_42", bcd1, 12'h042);

    repeat (80) do_edge($urandom_range(0, 3) == 0, 9'($urandom_range(0, 511)));
    idle(12);
    chk("queue_drained", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
